imem_responder: RTL and testbench

- Responder end of the instruction-fetch read interface: a stalling, fixed-latency instruction memory that accepts a read from the fetch stage and returns a 16-bit instruction word after LATENCY cycles.
- Drives `stall` so fetch holds its PC register, and pulses `done` when the word is valid.
- Has a load port for preloading program images from the bench or the boot path.

---
 rtl/imem_defs.sv | 24 ++
 rtl/imem_responder_if.sv | 22 ++
 rtl/imem_byte_ram.sv | 24 ++
 rtl/imem_responder.sv | 90 +++++++++
 tb/tb_imem_responder.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/imem_defs.sv
// Shared definitions for the instruction-memory responder: state encoding,
// counter width, default geometry and the response-hold record.
package imem_defs;

  typedef enum logic {
    IMEM_IDLE = 1'b0,
    IMEM_WAIT = 1'b1
  } imem_state_e;

  localparam int IMEM_CNT_W   = 4;
  localparam int IMEM_LATENCY = 4;
  localparam int IMEM_MEM_AW  = 16;

  typedef struct packed {
    logic [15:0] word;
    logic        err;
  } imem_rsp_t;

  // A flagged response never leaks the aligned word onto the bus.
  function automatic logic [15:0] imem_rsp_data(input imem_rsp_t r);
    return r.err ? 16'h0000 : r.word;
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch-side read bus plus preload port for the instruction memory.
interface imem_responder_if;
  logic        rd;
  logic [15:0] addr;
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [15:0] ld_data;
  logic [15:0] data_out;
  logic        done;
  logic        stall;
  logic        err;

  modport master (
    output rd, addr, ld_en, ld_addr, ld_data,
    input  data_out, done, stall, err
  );

  modport slave (
    input  rd, addr, ld_en, ld_addr, ld_data,
    output data_out, done, stall, err
  );
endinterface

// File: rtl/imem_byte_ram.sv
// Byte-wide array with one 2-byte synchronous write port and one 2-byte
// asynchronous read port, both addressed by word (big-endian byte order).
module imem_byte_ram #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-2:0] wr_waddr,
  input  logic [15:0]   wr_data,
  input  logic [AW-2:0] rd_waddr,
  output logic [15:0]   rd_data
);
  logic [7:0] mem [2**AW];

  // Even base address, so base+1 is just bit0 set and wraps within the array.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_waddr, 1'b0}] <= wr_data[15:8];
      mem[{wr_waddr, 1'b1}] <= wr_data[7:0];
    end
  end

  assign rd_data = {mem[{rd_waddr, 1'b0}], mem[{rd_waddr, 1'b1}]};
endmodule

// File: rtl/imem_responder.sv
// Stalling fixed-latency instruction memory responder.
// Optional misaligned-request flagging is enabled by defining IMEM_ALIGN_CHK_EN.
module imem_responder
  import imem_defs::*;
#(
  parameter int MEM_AW  = IMEM_MEM_AW,
  parameter int LATENCY = IMEM_LATENCY
) (
  input logic             clk,
  input logic             rst,
  imem_responder_if.slave bus
);
  localparam logic [IMEM_CNT_W-1:0] CNT_INIT =
    (LATENCY > 1) ? IMEM_CNT_W'(LATENCY - 2) : '0;

  imem_state_e             state;
  logic [IMEM_CNT_W-1:0]   cnt;
  imem_rsp_t               hold, fetch;
  logic [15:0]             ram_word;
  logic                    mis;
  logic                    accept;
  logic [15:0]             data_q;
  logic                    done_q, err_q;
  logic                    unused_addr_bits;

  imem_byte_ram #(.AW(MEM_AW)) u_ram (
    .clk      (clk),
    .wr_en    (bus.ld_en),
    .wr_waddr (bus.ld_addr[MEM_AW-1:1]),
    .wr_data  (bus.ld_data),
    .rd_waddr (bus.addr[MEM_AW-1:1]),
    .rd_data  (ram_word)
  );

`ifdef IMEM_ALIGN_CHK_EN
  assign mis = bus.addr[0];
`else
  assign mis = 1'b0;
`endif

  // Upper bits alias and bit0 is dropped for word addressing.
  assign unused_addr_bits = ^{bus.addr, bus.ld_addr};

  assign fetch.word = ram_word;
  assign fetch.err  = mis;

  // done only ever rises on the edge returning to IDLE, so IDLE alone
  // covers the back-to-back accept in the done cycle.
  assign accept = bus.rd && (state == IMEM_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IMEM_IDLE;
      cnt    <= '0;
      hold   <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      data_q <= '0;
      if (state == IMEM_WAIT) begin
        if (cnt == '0) begin
          state  <= IMEM_IDLE;
          done_q <= 1'b1;
          err_q  <= hold.err;
          data_q <= imem_rsp_data(hold);
        end else begin
          cnt <= cnt - 1'b1;
        end
      end else if (accept) begin
        hold <= fetch;
        if (LATENCY == 1) begin
          done_q <= 1'b1;
          err_q  <= fetch.err;
          data_q <= imem_rsp_data(fetch);
        end else begin
          state <= IMEM_WAIT;
          cnt   <= CNT_INIT;
        end
      end
    end
  end

  assign bus.stall    = (state == IMEM_WAIT);
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.data_out = data_q;
endmodule

// File: tb/tb_imem_responder.sv
// Randomized + directed bench for imem_responder against a transaction-level
// model (byte array, accept time and response time arithmetic).
module tb_imem_responder;
  localparam int L = 4;

  logic clk = 1'b0;
  logic rst;
  imem_responder_if bus();

  imem_responder #(.MEM_AW(16), .LATENCY(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mm [65536];
  int          k      = 0;
  int          last_t = -100;
  logic [15:0] exp_word;
  logic        exp_mis;
  int          ndone  = 0;
  logic [15:0] last_dout;
  logic        last_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (edge %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic step(input logic r, input logic rdv, input logic [15:0] a,
                      input logic le, input logic [15:0] la, input logic [15:0] ldv);
    logic [15:0] ma, lb;
    logic        done_e, stall_e;
    logic [15:0] data_e;
    rst = r; bus.rd = rdv; bus.addr = a;
    bus.ld_en = le; bus.ld_addr = la; bus.ld_data = ldv;
    @(posedge clk);
    if (!r) begin
      last_t = -100;
    end else if (rdv && k >= last_t + L) begin
      last_t   = k;
      ma       = a & 16'hFFFE;
      exp_word = {mm[ma], mm[ma + 16'd1]};
`ifdef IMEM_ALIGN_CHK_EN
      exp_mis  = a[0];
`else
      exp_mis  = 1'b0;
`endif
    end
    if (le) begin
      lb = la & 16'hFFFE;
      mm[lb]         = ldv[15:8];
      mm[lb + 16'd1] = ldv[7:0];
    end
    done_e  = (last_t >= 0) && (k == last_t + L - 1);
    stall_e = (last_t >= 0) && (k >= last_t) && (k <= last_t + L - 2);
    data_e  = (done_e && !exp_mis) ? exp_word : 16'h0000;
    @(negedge clk);
    chk("done",  {31'd0, bus.done},  {31'd0, done_e});
    chk("stall", {31'd0, bus.stall}, {31'd0, stall_e});
    chk("data",  {16'd0, bus.data_out}, {16'd0, data_e});
    chk("err",   {31'd0, bus.err},   {31'd0, done_e && exp_mis});
    if (bus.done) begin
      ndone++;
      last_dout = bus.data_out;
      last_err  = bus.err;
    end
    k++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic ld(input logic [15:0] la, input logic [15:0] d);
    step(1'b1, 1'b0, 16'h0, 1'b1, la, d);
  endtask

  // Issue one read and stop in the cycle where its response is visible.
  task automatic rd_wait(input logic [15:0] a);
    step(1'b1, 1'b1, a, 1'b0, 16'h0, 16'h0);
    idle(L - 1);
  endtask

  initial begin
    int n0;
    logic r, rv, le;
    logic [15:0] a, la;

    // Reset with rd asserted must not start anything.
    step(1'b0, 1'b1, 16'h0010, 1'b0, 16'h0, 16'h0);
    step(1'b0, 1'b1, 16'h0010, 1'b0, 16'h0, 16'h0);
    chk("rst_data", {16'd0, bus.data_out}, 32'd0);

    for (int w = 0; w < 64; w++) ld(16'(w * 2), 16'($urandom));
    ld(16'h0010, 16'h1234);
    ld(16'h0000, 16'hAAAA);
    ld(16'h0002, 16'hBBBB);
    ld(16'h0020, 16'h0F0F);
    ld(16'hFFFE, 16'hC3D4);

    // Reset again: array survives, first rd after release is accepted.
    step(1'b0, 1'b1, 16'h0010, 1'b0, 16'h0, 16'h0);
    step(1'b0, 1'b1, 16'h0010, 1'b0, 16'h0, 16'h0);
    n0 = ndone;
    rd_wait(16'h0010);
    chk("rel_done", {31'd0, bus.done}, 32'd1);
    chk("rel_word", {16'd0, last_dout}, 32'h1234);

    idle(2);
    rd_wait(16'h0010);
    chk("basic_word", {16'd0, bus.data_out}, 32'h1234);
    chk("basic_nstall", {31'd0, bus.stall}, 32'd0);

    // Back-to-back with rd held, then a WAIT-time pulse that must be ignored.
    idle(1);
    n0 = ndone;
    for (int i = 0; i < L; i++) step(1'b1, 1'b1, 16'h0000, 1'b0, 16'h0, 16'h0);
    chk("b2b_a", {16'd0, bus.data_out}, 32'hAAAA);
    step(1'b1, 1'b1, 16'h0002, 1'b0, 16'h0, 16'h0);
    idle(1);
    step(1'b1, 1'b1, 16'h0000, 1'b0, 16'h0, 16'h0);
    idle(L + 2);
    chk("b2b_b", {16'd0, last_dout}, 32'hBBBB);
    chk("b2b_cnt", ndone - n0, 32'd2);

    rd_wait(16'hFFFE);
    chk("wrap", {16'd0, bus.data_out}, 32'hC3D4);

    // Same-edge load and read of one word returns the old contents.
    idle(1);
    step(1'b1, 1'b1, 16'h0020, 1'b1, 16'h0020, 16'h5555);
    idle(L - 1);
    chk("coll_old", {16'd0, bus.data_out}, 32'h0F0F);
    rd_wait(16'h0020);
    chk("coll_new", {16'd0, bus.data_out}, 32'h5555);

    // Abort: reset during WAIT kills the response.
    idle(1);
    n0 = ndone;
    step(1'b1, 1'b1, 16'h0010, 1'b0, 16'h0, 16'h0);
    idle(1);
    step(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    chk("abort_stall", {31'd0, bus.stall}, 32'd0);
    idle(L + 3);
    chk("abort_cnt", ndone - n0, 32'd0);

    rd_wait(16'h0011);
`ifdef IMEM_ALIGN_CHK_EN
    chk("mis_err",  {31'd0, bus.err}, 32'd1);
    chk("mis_data", {16'd0, bus.data_out}, 32'd0);
`else
    chk("mis_err",  {31'd0, bus.err}, 32'd0);
    chk("mis_data", {16'd0, bus.data_out}, 32'h1234);
`endif

    // Random traffic confined to loaded words.
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(99) != 0);
      rv = $urandom_range(1);
      a  = ($urandom_range(15) == 0) ? 16'hFFFE | 16'($urandom_range(1))
                                     : 16'($urandom_range(127));
      le = ($urandom_range(3) == 0);
      la = 16'($urandom_range(127));
      step(r, rv, a, le, la, 16'($urandom));
    end
    idle(L + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
